// File: rtl/psum_deskew_pkg.sv
// Widths shared by the PE row, the activation feeder and the partial-sum collector,
// plus the helper that locates one column inside a packed multi-column bus.
package psum_deskew_pkg;

  localparam int SUM_W = 64;
  localparam int ACT_W = 32;

  // Low bit index of column col in a bus of SUM_W-wide columns.
  function automatic int col_lo(input int col);
    return col * SUM_W;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO holding aligned result vectors.
// The head is presented combinationally from the storage registers.
module psum_fifo
  import psum_deskew_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign dout      = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/psum_deskew.sv
// Realigns the skewed bottom-row partial sums of the array into whole vectors,
// buffers them, and issues launch credit to the array controller.
module psum_deskew
  import psum_deskew_pkg::*;
#(
  parameter int NUM   = 16,
  parameter int DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic                 in_valid,
  input  logic [NUM*SUM_W-1:0] in_sum,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM*SUM_W-1:0] out_sum,
  output logic                 OVERFLOW
);

  localparam int IW = $clog2(NUM + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 accept;
  logic                 push;
  logic                 tag_last;
  logic [IW-1:0]        inflight;
  logic [CW-1:0]        count;
  logic [NUM*SUM_W-1:0] aligned;

  // Handshakes: a vector enters on an EN step with in_valid && in_ready;
  // a result leaves on any cycle with out_valid && out_ready.
  // Credit counts both buffered and in-flight vectors, so a push never meets a full FIFO.
  assign accept   = EN && in_valid && in_ready;
  assign push     = EN && tag_last;
  assign in_ready = (int'(count) + int'(inflight)) < DEPTH;

  if (NUM == 1) begin : g_tag_direct
    assign tag_last = accept;
  end else begin : g_tag
    logic [NUM-2:0] vld;
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        vld <= '0;
      end else if (EN) begin
        vld[0] <= accept;
        for (int i = 1; i < NUM - 1; i++) vld[i] <= vld[i-1];
      end
    end
    assign tag_last = vld[NUM-2];
  end

  // Column c arrives c steps late, so it waits NUM-1-c steps to line up with the last column.
  for (genvar c = 0; c < NUM; c++) begin : g_col
    localparam int D = NUM - 1 - c;
    if (D == 0) begin : g_direct
      assign aligned[col_lo(c) +: SUM_W] = in_sum[col_lo(c) +: SUM_W];
    end else begin : g_dly
      logic [SUM_W-1:0] dly [D];
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          for (int j = 0; j < D; j++) dly[j] <= '0;
        end else if (EN) begin
          dly[0] <= in_sum[col_lo(c) +: SUM_W];
          for (int j = 1; j < D; j++) dly[j] <= dly[j-1];
        end
      end
      assign aligned[col_lo(c) +: SUM_W] = dly[D-1];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      inflight <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (EN && in_valid && !in_ready) OVERFLOW <= 1'b1;
      if (accept && !push)      inflight <= inflight + IW'(1);
      else if (!accept && push) inflight <= inflight - IW'(1);
    end
  end

  psum_fifo #(
    .W     (NUM * SUM_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .din       (aligned),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (out_sum),
    .count     (count)
  );

endmodule

// File: tb/tb_psum_deskew.sv
// Bench for psum_deskew with NUM=4: instance a uses DEPTH=4, instance b uses DEPTH=8
// so that full-rate streaming never runs out of credit.
`timescale 1ns/1ps
module tb_psum_deskew;
  import psum_deskew_pkg::*;

  localparam int NUM = 4;
  localparam int W   = NUM * SUM_W;

  logic         CLK = 1'b0;
  logic         RESET, EN, in_valid, out_ready;
  logic [W-1:0] in_sum;
  logic         in_ready_a, out_valid_a, overflow_a;
  logic         in_ready_b, out_valid_b, overflow_b;
  logic [W-1:0] out_sum_a, out_sum_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a[$];
  logic [W-1:0] got_b[$];
  int           gt_a[$];
  int           gt_b[$];

  int          vstart[16];
  logic [31:0] vtag[16];
  int          last_t[16];
  int          nvec, s_idx, vbase;

  // ---------------- clock / reset / DUTs ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  psum_deskew #(.NUM(NUM), .DEPTH(4)) dut_a (
    .CLK(CLK), .RESET(RESET), .EN(EN), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .OVERFLOW(overflow_a)
  );

  psum_deskew #(.NUM(NUM), .DEPTH(8)) dut_b (
    .CLK(CLK), .RESET(RESET), .EN(EN), .in_valid(in_valid), .in_sum(in_sum),
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .OVERFLOW(overflow_b)
  );

  // Output collector: every accepted beat with the cycle it was presented in.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (out_valid_a && out_ready) begin got_a.push_back(out_sum_a); gt_a.push_back(cyc); end
      if (out_valid_b && out_ready) begin got_b.push_back(out_sum_b); gt_b.push_back(cyc); end
    end
  end

  // ---------------- stimulus model ----------------
  function automatic logic [SUM_W-1:0] col_val(input int v, input int c);
    return {vtag[v], 32'(vbase + 16 * v + c)};
  endfunction

  function automatic logic [W-1:0] vec_val(input int v);
    logic [W-1:0] r;
    for (int c = 0; c < NUM; c++) r[c*SUM_W +: SUM_W] = col_val(v, c);
    return r;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    RESET = 1'b1; EN = 1'b0; in_valid = 1'b0; in_sum = '0; out_ready = 1'b0;
    tick; tick;
    RESET = 1'b0;
    tick;
    exp_q.delete(); got_a.delete(); got_b.delete(); gt_a.delete(); gt_b.delete();
    nvec = 0; s_idx = 0; vbase = 0;
  endtask

  // One EN step; column c carries the vector launched c steps ago, 0xDEAD otherwise.
  task automatic drive_step(input bit valid, input bit keep);
    EN = 1'b1;
    in_valid = valid;
    if (valid) begin
      vstart[nvec] = s_idx;
      vtag[nvec]   = keep ? 32'h0 : 32'hBAD0_0000;
      if (keep) exp_q.push_back(vec_val(nvec));
      nvec++;
    end
    for (int c = 0; c < NUM; c++) in_sum[c*SUM_W +: SUM_W] = 64'hDEAD;
    for (int v = 0; v < nvec; v++) begin
      for (int c = 0; c < NUM; c++)
        if (vstart[v] + c == s_idx) in_sum[c*SUM_W +: SUM_W] = col_val(v, c);
      if (vstart[v] + NUM - 1 == s_idx) last_t[v] = cyc + 1;
    end
    tick;
    s_idx++;
  endtask

  // Non-step cycle with garbage on the inputs.
  task automatic idle_cycle;
    EN = 1'b0;
    in_valid = 1'($urandom_range(0, 1));
    for (int c = 0; c < NUM; c++) in_sum[c*SUM_W +: SUM_W] = {$urandom, $urandom};
    tick;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid_a); end
    n_vec++; if (out_sum_a !== '0) begin n_err++; $display("FAIL reset_out_sum got %h exp 0", out_sum_a); end
    n_vec++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready_a); end
  endtask

  task automatic test_single;
    logic [W-1:0] want;
    do_reset;
    out_ready = 1'b1;
    vbase = 'h100;
    want = {64'h103, 64'h102, 64'h101, 64'h100};
    drive_step(1'b1, 1'b1);
    for (int s = 1; s < NUM; s++) drive_step(1'b0, 1'b0);
    for (int k = 0; k < 6; k++) idle_cycle;
    n_vec++; if (got_a.size() !== 1) begin n_err++; $display("FAIL single_beats got %0d exp 1", got_a.size()); end
    if (got_a.size() > 0) begin
      n_vec++; if (got_a[0] !== want) begin n_err++; $display("FAIL single_data got %h exp %h", got_a[0], want); end
      n_vec++; if (gt_a[0] !== last_t[0]) begin n_err++; $display("FAIL single_latency got cycle %0d exp %0d", gt_a[0], last_t[0]); end
    end
  endtask

  task automatic run_stream(input bit toggle, input string name);
    do_reset;
    out_ready = 1'b1;
    for (int s = 0; s < 8 + NUM - 1; s++) begin
      if (s < 8) begin
        n_vec++;
        if (in_ready_b !== 1'b1) begin n_err++; $display("FAIL %s_in_ready step %0d got %b exp 1", name, s, in_ready_b); end
      end
      drive_step(s < 8, 1'b1);
      if (toggle) idle_cycle;
    end
    for (int k = 0; k < 6; k++) idle_cycle;
    n_vec++; if (got_b.size() !== exp_q.size()) begin n_err++; $display("FAIL %s_beats got %0d exp %0d", name, got_b.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_b.size(); k++) begin
      n_vec++; if (got_b[k] !== exp_q[k]) begin n_err++; $display("FAIL %s_data[%0d] got %h exp %h", name, k, got_b[k], exp_q[k]); end
      n_vec++; if (gt_b[k] !== last_t[k]) begin n_err++; $display("FAIL %s_time[%0d] got %0d exp %0d", name, k, gt_b[k], last_t[k]); end
    end
    n_vec++; if (overflow_b !== 1'b0) begin n_err++; $display("FAIL %s_overflow got %b exp 0", name, overflow_b); end
  endtask

  task automatic test_back_to_back;
    run_stream(1'b0, "b2b");
  endtask

  task automatic test_en_toggle;
    run_stream(1'b1, "en_toggle");
  endtask

  task automatic test_backpressure;
    do_reset;
    vbase = 'h200;
    for (int s = 0; s < 4; s++) begin
      n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL bp_in_ready accept %0d got %b exp 1", s, in_ready_a); end
      drive_step(1'b1, 1'b1);
    end
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL bp_credit_out got %b exp 0", in_ready_a); end
    n_vec++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL bp_overflow_early got %b exp 0", overflow_a); end
    drive_step(1'b1, 1'b0);
    n_vec++; if (overflow_a !== 1'b1) begin n_err++; $display("FAIL bp_overflow_set got %b exp 1", overflow_a); end
    for (int s = 0; s < 3; s++) drive_step(1'b0, 1'b0);
    EN = 1'b0; in_valid = 1'b0;
    tick; tick;
    n_vec++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL bp_full_valid got %b exp 1", out_valid_a); end
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready got %b exp 0", in_ready_a); end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick;
    n_vec++; if (got_a.size() !== 4) begin n_err++; $display("FAIL bp_beats got %0d exp 4", got_a.size()); end
    for (int k = 0; k < exp_q.size() && k < got_a.size(); k++) begin
      n_vec++; if (got_a[k] !== exp_q[k]) begin n_err++; $display("FAIL bp_data[%0d] got %h exp %h", k, got_a[k], exp_q[k]); end
    end
    n_vec++; if (overflow_a !== 1'b1) begin n_err++; $display("FAIL bp_overflow_sticky got %b exp 1", overflow_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL bp_credit_back got %b exp 1", in_ready_a); end
  endtask

  // Runs straight after test_backpressure so OVERFLOW is still set going in.
  task automatic test_reset_midflight;
    exp_q.delete(); got_a.delete(); gt_a.delete(); nvec = 0;
    out_ready = 1'b0;
    drive_step(1'b1, 1'b1);
    drive_step(1'b0, 1'b0);
    drive_step(1'b0, 1'b0);
    drive_step(1'b1, 1'b1);
    drive_step(1'b0, 1'b0);
    n_vec++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b exp 1", out_valid_a); end
    EN = 1'b1; in_valid = 1'b0;
    #2 RESET = 1'b1;
    @(negedge CLK);
    n_vec++; if (out_valid_a !== 1'b0) begin n_err++; $display("FAIL mid_out_valid got %b exp 0", out_valid_a); end
    n_vec++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL mid_overflow got %b exp 0", overflow_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL mid_in_ready got %b exp 1", in_ready_a); end
    tick;
    RESET = 1'b0;
    exp_q.delete(); got_a.delete(); gt_a.delete(); nvec = 0;
    out_ready = 1'b1;
    for (int s = 0; s < 6; s++) drive_step(1'b0, 1'b0);
    EN = 1'b0;
    tick; tick;
    n_vec++; if (got_a.size() !== 0) begin n_err++; $display("FAIL mid_stray_beats got %0d exp 0", got_a.size()); end
  endtask

  task automatic test_full_pop_push;
    do_reset;
    vbase = 'h300;
    for (int s = 0; s < 4; s++) drive_step(1'b1, 1'b1);
    drive_step(1'b0, 1'b0);
    drive_step(1'b0, 1'b0);
    out_ready = 1'b1;
    drive_step(1'b0, 1'b0);
    out_ready = 1'b0;
    n_vec++; if (got_a.size() !== 1) begin n_err++; $display("FAIL fpp_popped got %0d exp 1", got_a.size()); end
    n_vec++; if (out_valid_a !== 1'b1) begin n_err++; $display("FAIL fpp_valid got %b exp 1", out_valid_a); end
    n_vec++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL fpp_credit got %b exp 1", in_ready_a); end
    drive_step(1'b1, 1'b1);
    n_vec++; if (in_ready_a !== 1'b0) begin n_err++; $display("FAIL fpp_count3 in_ready got %b exp 0", in_ready_a); end
    for (int s = 0; s < 3; s++) drive_step(1'b0, 1'b0);
    EN = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) tick;
    n_vec++; if (got_a.size() !== 5) begin n_err++; $display("FAIL fpp_beats got %0d exp 5", got_a.size()); end
    for (int k = 0; k < exp_q.size() && k < got_a.size(); k++) begin
      n_vec++; if (got_a[k] !== exp_q[k]) begin n_err++; $display("FAIL fpp_data[%0d] got %h exp %h", k, got_a[k], exp_q[k]); end
    end
    n_vec++; if (overflow_a !== 1'b0) begin n_err++; $display("FAIL fpp_overflow got %b exp 0", overflow_a); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_en_toggle;
    test_backpressure;
    test_reset_midflight;
    test_full_pop_push;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_deskew.md
# psum_deskew

Output collector that sits directly below the last PE row of the systolic array. It consumes the row's skewed 64-bit partial-sum bus, where column i's result emerges i array-steps after column 0. It re-aligns the columns into one coherent NUM-wide result vector and buffers these vectors in a small FIFO. The FIFO is drained through a valid/ready handshake toward the writeback logic, and a credit signal tells the array controller when it may launch another vector.

## Interface
- NUM, 16: number of PE columns (≥1)
- DEPTH, 4: result FIFO depth in vectors (≥2, power of two)
- CLK  in  1  single clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state
- EN  in  1  array step strobe; skew pipeline advances only when EN=1
- in_valid  in  1  column 0 of in_sum carries the first element of a new result vector this step
- in_sum  in  NUM*64  bottom-row out_sum bus; column i at [(i+1)*64-1:i*64]
- in_ready  out  1  credit: a new vector may be started (in_valid) this step
- out_valid  out  1  FIFO head holds an aligned vector
- out_ready  in  1  consumer accepts head
- out_sum  out  NUM*64  aligned vector, column i at [(i+1)*64-1:i*64]
- OVERFLOW  out  1  sticky error: in_valid issued without credit

## Operation
- Step = cycle with EN=1. A vector is accepted when EN&&in_valid&&in_ready.
- Column i of an accepted vector is sampled at step k+i, where k is the acceptance step.
- Deskew: column i passes through NUM-1-i EN-gated registers (triangular delay array). Column NUM-1 is direct. All columns are therefore aligned at step k+NUM-1.
- Tag shift register vld[NUM-1:0]: shifts on EN, bit 0 = accepted. A push occurs at a step whose tag reaches position NUM-1. For NUM=1, the push happens at the acceptance step.
- inflight counter (0..NUM): +1 on accept, -1 on push; both in the same step leaves it unchanged.
- FIFO: count 0..DEPTH, wrap-around read/write pointers. Pop = out_valid&&out_ready, independent of EN. Simultaneous push and pop leaves count unchanged, with data order preserved.
- in_ready = (count + inflight) < DEPTH, decoded from registers only. This guarantees a push never meets a full FIFO.
- Credit violation (EN&&in_valid&&!in_ready): the vector is not tagged and OVERFLOW is set (held until RESET). Existing FIFO and in-flight data are unaffected. Columns of the dropped vector are still shifted but never pushed.
- in_valid with EN=0 is ignored: no accept, no flag.
- Sums pass through unmodified (no arithmetic, no truncation).

## Timing
- Reset values: out_valid=0, out_sum=0, OVERFLOW=0, count=0, inflight=0, vld=0, delay registers=0. in_ready=1.
- Latency: out_valid rises the cycle after step k+NUM-1 (registered FIFO output). With EN continuously high, this is NUM cycles after acceptance.
- out_sum holds its value while out_valid&&!out_ready, and updates the cycle after a pop.
- Throughput: one vector per step when out_ready=1.
- in_ready reflects a pop on the following cycle.
- RESET mid-operation: all in-flight and buffered vectors are discarded immediately, with no partial output.

## Structure
- Shared package: SUM_W=64 and ACT_W=32 width constants, plus a column-slice helper function. These are used by PE_row, this block, and the activation feeder.
- Sub-module psum_fifo: synchronous FIFO, width NUM*SUM_W, DEPTH entries, with push/pop/count/out_valid.
- Deskew triangle and credit logic live in the top level, built with a generate loop over columns.

## Test plan
- NUM=4: accept one vector; feed column i = 0x100+i at step i, with all other values 0xDEAD. Required: out_valid one cycle after step 3, out_sum = {0x103,0x102,0x101,0x100}, one beat only.
- NUM=4, EN=1, out_ready=1: accept vectors each step, with vector v column i = 16*v+i for v=0..7. Required: 8 consecutive aligned outputs in order, and in_ready stays 1.
- Same stimulus with EN toggling 1/0 each cycle and random values on non-EN cycles. Required: identical outputs, each out_valid following the last column's step.
- DEPTH=4, out_ready=0, accept until in_ready=0. Required: in_ready drops after exactly 4 accepts. A 5th in_valid sets OVERFLOW=1, and 4 correct vectors drain afterwards.
- Full FIFO with the last vector in flight and pop plus push in the same cycle. Required: count unchanged and order intact.
- Assert RESET at step 2 of a vector in flight. Required: out_valid=0, OVERFLOW=0, in_ready=1 next cycle, and no stray output after release.
